// File: rtl/cv32e40s_pkg.sv
// cv32e40s_pkg: shared types, opcodes and Zcmp encode/decode helpers
package cv32e40s_pkg;
  localparam logic [6:0] OPCODE_STORE = 7'h23;
  localparam logic [6:0] OPCODE_LOAD  = 7'h03;
  localparam logic [6:0] OPCODE_OPIMM = 7'h13;
  localparam logic [6:0] OPCODE_JALR  = 7'h67;

  typedef enum logic [2:0] {ZC_NONE, ZC_PUSH, ZC_POP, ZC_POPRETZ, ZC_POPRET, ZC_MVSA01, ZC_MVA01S} zcmp_op_e;
  typedef enum logic {S_IDLE, S_SEQ} seq_state_e;

  localparam logic [31:0] JALR_RA = {12'd0, 5'd1, 3'b000, 5'd0, OPCODE_JALR};

  // s-register index to architectural register: s0..s1 = x8..x9, s2..s11 = x18..x27
  function automatic logic [4:0] sreg(logic [3:0] i);
    return (i < 4'd2) ? 5'd8 + {1'b0, i} : 5'd16 + {1'b0, i};
  endfunction

  function automatic logic [31:0] enc_i(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OPCODE_OPIMM};
  endfunction

  function automatic logic [31:0] enc_l(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, OPCODE_LOAD};
  endfunction

  function automatic logic [31:0] enc_s(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPCODE_STORE};
  endfunction

  // Reserved encodings decode to ZC_NONE so they reach the decoder untouched
  function automatic zcmp_op_e zc_decode(logic [15:0] c);
    if (c[1:0] != 2'b10 || c[15:13] != 3'b101) return ZC_NONE;
    if (c[12:10] == 3'b011) begin
      if (c[6:5] == 2'b01) return (c[9:7] == c[4:2]) ? ZC_NONE : ZC_MVSA01;
      if (c[6:5] == 2'b11) return ZC_MVA01S;
      return ZC_NONE;
    end
    if (c[7:4] < 4'd4) return ZC_NONE;
    case (c[12:8])
      5'b11000: return ZC_PUSH;
      5'b11010: return ZC_POP;
      5'b11100: return ZC_POPRETZ;
      5'b11110: return ZC_POPRET;
      default:  return ZC_NONE;
    endcase
  endfunction
endpackage

// File: rtl/cv32e40s_zcmp_expander.sv
// cv32e40s_zcmp_expander: maps (instruction, step) to one expanded RV32I operation
module cv32e40s_zcmp_expander
  import cv32e40s_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [3:0]  step_i,
  output logic [31:0] instr_o,
  output logic        last_o
);
  zcmp_op_e    op;
  logic [3:0]  n, j, u;
  logic [2:0]  cq;
  logic [4:0]  rk, r1s, r2s;
  logic [6:0]  adj;
  logic [11:0] off, adj12;
  logic        mem;
  // Derive list size, stack adjustment and the operation for this step
  always_comb begin
    op      = zc_decode(instr_i[15:0]);
    n       = (instr_i[7:4] == 4'd15) ? 4'd13 : instr_i[7:4] - 4'd3;
    cq      = 3'(({1'b0, n} + 5'd3) >> 2);
    adj     = {cq, 4'b0} + {1'b0, instr_i[3:2], 4'b0};
    adj12   = {5'b0, adj};
    j       = n - step_i - 4'd1;
    rk      = (j == 4'd0) ? 5'd1 : sreg(j - 4'd1);
    off     = {6'b0, step_i + 4'd1, 2'b0};
    mem     = step_i < n;
    u       = step_i - n + ((op == ZC_POPRETZ) ? 4'd0 : 4'd1);
    r1s     = sreg({1'b0, instr_i[9:7]});
    r2s     = sreg({1'b0, instr_i[4:2]});
    instr_o = instr_i;
    last_o  = 1'b1;
    case (op)
      ZC_PUSH: begin
        instr_o = mem ? enc_s(rk, 5'd2, 12'd0 - off) : enc_i(5'd2, 5'd2, 12'd0 - adj12);
        last_o  = step_i == n;
      end
      ZC_POP, ZC_POPRET, ZC_POPRETZ: begin
        instr_o = mem ? enc_l(rk, 5'd2, adj12 - off) :
                  (u == 4'd1) ? enc_i(5'd2, 5'd2, adj12) :
                  (u == 4'd2) ? JALR_RA : enc_i(5'd10, 5'd0, 12'd0);
        last_o  = !mem && u == ((op == ZC_POP) ? 4'd1 : 4'd2);
      end
      ZC_MVSA01: begin
        instr_o = (step_i == 4'd0) ? enc_i(r1s, 5'd10, 12'd0) : enc_i(r2s, 5'd11, 12'd0);
        last_o  = step_i == 4'd1;
      end
      ZC_MVA01S: begin
        instr_o = (step_i == 4'd0) ? enc_i(5'd10, r1s, 12'd0) : enc_i(5'd11, r2s, 12'd0);
        last_o  = step_i == 4'd1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cv32e40s_zcmp_sequencer.sv
// cv32e40s_zcmp_sequencer: issues Zcmp instructions as RV32I sequences, passes others through
module cv32e40s_zcmp_sequencer
  import cv32e40s_pkg::*;
#(
  parameter bit ZC_EXT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        kill_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        seq_instr_o,
  output logic        seq_first_o,
  output logic        seq_last_o
);
  if (ZC_EXT) begin : g_zc
    seq_state_e  state, state_n;
    logic [3:0]  step, step_n, exp_step;
    logic [31:0] instr_q, instr_n, exp_in, exp_instr;
    logic        exp_last, active;
    assign exp_in   = (state == S_SEQ) ? instr_q : instr_i;
    assign exp_step = (state == S_SEQ) ? step : 4'd0;
    cv32e40s_zcmp_expander u_exp (
      .instr_i (exp_in),
      .step_i  (exp_step),
      .instr_o (exp_instr),
      .last_o  (exp_last)
    );
    // State, step counter and captured instruction
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= S_IDLE;
        step    <= 4'd0;
        instr_q <= 32'd0;
      end else begin
        state   <= state_n;
        step    <= step_n;
        instr_q <= instr_n;
      end
    end
    // Advance one step per accepted operation; kill returns to IDLE
    always_comb begin
      state_n = state;
      step_n  = step;
      instr_n = instr_q;
      if (kill_i) begin
        state_n = S_IDLE;
        step_n  = 4'd0;
      end else if (active && instr_ready_i) begin
        state_n = exp_last ? S_IDLE : S_SEQ;
        step_n  = exp_last ? 4'd0 : exp_step + 4'd1;
        instr_n = (state == S_IDLE) ? instr_i : instr_q;
      end
    end
    // Handshake and sequence flags
    always_comb begin
      active        = (state == S_SEQ) || (instr_valid_i && zc_decode(instr_i[15:0]) != ZC_NONE);
      instr_o       = active ? exp_instr : instr_i;
      seq_instr_o   = active;
      seq_first_o   = active && state == S_IDLE;
      seq_last_o    = !active || exp_last;
      instr_valid_o = !kill_i && (state == S_SEQ || instr_valid_i);
      instr_ready_o = !kill_i && instr_valid_i && instr_ready_i && seq_last_o;
    end
  end else begin : g_pass
    assign instr_o       = instr_i;
    assign instr_valid_o = instr_valid_i && !kill_i;
    assign instr_ready_o = instr_valid_i && instr_ready_i && !kill_i;
    assign seq_instr_o   = 1'b0;
    assign seq_first_o   = 1'b0;
    assign seq_last_o    = 1'b1;
  end
endmodule

// File: tb/tb_cv32e40s_zcmp_sequencer.sv
// tb_cv32e40s_zcmp_sequencer: directed and random checks against a list-based reference model
module tb_cv32e40s_zcmp_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        kill_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        seq_instr_o;
  logic        seq_first_o;
  logic        seq_last_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  bit          exp_zc;
  bit          rdy_pat[$];
  int          sregs[12] = '{8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};

  cv32e40s_zcmp_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .kill_i        (kill_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .seq_instr_o   (seq_instr_o),
    .seq_first_o   (seq_first_o),
    .seq_last_o    (seq_last_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_addi(int rd, int rs1, int imm);
    logic [11:0] i;
    i = imm[11:0];
    return {i, 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] m_lw(int rd, int rs1, int imm);
    logic [11:0] i;
    i = imm[11:0];
    return {i, 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction

  function automatic logic [31:0] m_sw(int rs2, int rs1, int imm);
    logic [11:0] i;
    i = imm[11:0];
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'h23};
  endfunction

  task automatic model(input logic [31:0] ins);
    logic [15:0] c;
    int n, adj, r, kind, r1, r2;
    c = ins[15:0];
    kind = int'(c[12:8]);
    r1 = int'(c[9:7]);
    r2 = int'(c[4:2]);
    exp_q.delete();
    exp_zc = 1'b1;
    if (c[1:0] == 2'b10 && c[15:10] == 6'b101011 && c[6:5] == 2'b01 && r1 != r2) begin
      exp_q.push_back(m_addi(sregs[r1], 10, 0));
      exp_q.push_back(m_addi(sregs[r2], 11, 0));
    end else if (c[1:0] == 2'b10 && c[15:10] == 6'b101011 && c[6:5] == 2'b11) begin
      exp_q.push_back(m_addi(10, sregs[r1], 0));
      exp_q.push_back(m_addi(11, sregs[r2], 0));
    end else if (c[1:0] == 2'b10 && c[15:13] == 3'b101 && c[7:4] >= 4'd4 && kind inside {24, 26, 28, 30}) begin
      n = (c[7:4] == 4'd15) ? 13 : int'(c[7:4]) - 3;
      adj = (4 * n + 15) / 16 * 16 + 16 * int'(c[3:2]);
      for (int k = 0; k < n; k++) begin
        r = (n - 1 - k == 0) ? 1 : sregs[n - 2 - k];
        exp_q.push_back(kind == 24 ? m_sw(r, 2, -4 * (k + 1)) : m_lw(r, 2, adj - 4 * (k + 1)));
      end
      if (kind == 28) exp_q.push_back(m_addi(10, 0, 0));
      exp_q.push_back(m_addi(2, 2, kind == 24 ? -adj : adj));
      if (kind >= 28) exp_q.push_back(32'h00008067);
    end else begin
      exp_q.push_back(ins);
      exp_zc = 1'b0;
    end
  endtask

  task automatic run(input bit rnd);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    instr_valid_i = 1'b1;
    while (idx < exp_q.size() && guard < 100) begin
      instr_ready_i = rdy_pat.size() != 0 ? rdy_pat.pop_front() : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      check("instr", instr_o, exp_q[idx]);
      check("valid", instr_valid_o, 1);
      check("seq", seq_instr_o, exp_zc);
      check("first", seq_first_o, exp_zc && idx == 0);
      check("last", seq_last_o, idx == exp_q.size() - 1);
      check("rdy_o", instr_ready_o, instr_ready_i && idx == exp_q.size() - 1);
      @(posedge clk);
      #1;
      if (instr_ready_i) idx++;
      guard++;
    end
    check("ops_done", 32'(idx), 32'(exp_q.size()));
    instr_valid_i = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input bit rnd);
    instr_i = ins;
    model(ins);
    run(rnd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    kill_i = 1'b0;
    instr_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    instr_i = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instr_o, 32'h12345678);
    check("rst_valid", instr_valid_o, 0);
    check("rst_rdy", instr_ready_o, 0);
    check("rst_seq", seq_instr_o, 0);
    check("rst_first", seq_first_o, 0);
    check("rst_last", seq_last_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    instr_i = 32'h0000B852;
    exp_q = '{32'hFE812E23, 32'hFE112C23, 32'hFF010113};
    exp_zc = 1'b1;
    run(1'b0);
    do_instr(32'h0000BCFE, 1'b0);
    instr_i = 32'h0000AC2A;
    exp_q = '{32'h00050413, 32'h00058913};
    exp_zc = 1'b1;
    run(1'b0);
    instr_i = 32'h0000AD2A;
    exp_q = '{32'h0000AD2A};
    exp_zc = 1'b0;
    run(1'b0);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_instr(32'h0000B852, 1'b0);
    model(32'h0000BA62);
    instr_i = 32'h0000BA62;
    instr_valid_i = 1'b1;
    instr_ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pop_step2", instr_o, exp_q[2]);
    kill_i = 1'b1;
    @(negedge clk);
    check("kill_valid", instr_valid_o, 0);
    check("kill_rdy", instr_ready_o, 0);
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    instr_i = 32'h003100B3;
    @(negedge clk);
    check("post_kill_instr", instr_o, 32'h003100B3);
    check("post_kill_seq", seq_instr_o, 0);
    check("post_kill_valid", instr_valid_o, 1);
    check("post_kill_rdy", instr_ready_o, 1);
    @(posedge clk);
    #1;
    instr_i = 32'h0000B852;
    @(posedge clk);
    #1;
    check("pre_rst_instr", instr_o, 32'hFE112C23);
    instr_ready_i = 1'b0;
    #2;
    instr_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_instr", instr_o, 32'h0000B852);
    check("mid_rst_valid", instr_valid_o, 0);
    check("mid_rst_seq", seq_instr_o, 0);
    check("mid_rst_first", seq_first_o, 0);
    check("mid_rst_last", seq_last_o, 1);
    check("mid_rst_rdy", instr_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q = '{32'hFE812E23, 32'hFE112C23, 32'hFF010113};
    exp_zc = 1'b1;
    run(1'b0);
    for (int it = 0; it < 60; it++) begin
      logic [31:0] ins;
      int sel;
      ins = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: ins[1:0] = 2'b11;
        1, 2: ins[15:0] = {3'b101, 2'b11, 2'($urandom), 1'b0, 4'($urandom_range(4, 15)), 2'($urandom), 2'b10};
        3: ins[15:0] = {6'b101011, 3'($urandom), $urandom_range(0, 1) ? 2'b01 : 2'b11, 3'($urandom), 2'b10};
        4: ins[15:0] = {3'b101, 2'b11, 2'($urandom), 1'b0, 4'($urandom_range(0, 3)), 2'($urandom), 2'b10};
        default: ins[1:0] = 2'b10;
      endcase
      do_instr(ins, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
